// File: rtl/button_pkg.sv
// button_pkg: shared types and default counts for the push-button conditioner
// and the other lab input stages.
//   state_t                  debounce FSM states
//   DEFAULT_SYNC_STAGES      synchroniser depth used when none is given
//   DEFAULT_DEBOUNCE_CYCLES  stable synced cycles needed to accept a change
//                            (simulation value; the board build uses 100000)
//   DEFAULT_LONG_CYCLES      cycles held before long_press fires
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_LONG_CYCLES     = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: multi-flop synchroniser for a single asynchronous input bit.
// Reused by the other lab inputs, so it carries no button-specific logic.
// Ports:
//   clk    in  system clock, posedge
//   reset  in  asynchronous, active-high; clears every stage to 0
//   d      in  asynchronous input
//   q      out synchronised output (last stage of the chain)
module sync_2ff
    import button_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Stage 0 samples the raw input; each later stage takes the one before it.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises and debounces a raw push-button.
// Ports:
//   clk            in  system clock, posedge
//   reset          in  asynchronous, active-high
//   btn_raw        in  raw bouncing button, asynchronous to clk
//   btn_level      out debounced level, registered
//   press_pulse    out one-cycle pulse on an accepted 0->1, registered
//   release_pulse  out one-cycle pulse on an accepted 1->0, registered
//   long_press     out one-cycle pulse after LONG_CYCLES of hold, registered
// Build option: define LONG_PRESS_EN to include the hold counter and the
// long_press pulse. Without it long_press is a constant 0 and the port list
// is the same.
// A stable edge on btn_raw shows up on the outputs SYNC_STAGES +
// DEBOUNCE_CYCLES + 1 posedges later: SYNC_STAGES to cross the synchroniser,
// one to leave IDLE/HELD, DEBOUNCE_CYCLES in the WAIT state.
module button_conditioner
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
        $error("button_conditioner: SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1, LONG_CYCLES>=1");
    end

    logic sync;

    // Only the synchroniser looks at btn_raw.
    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (sync)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    // Bounce: drop back silently.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    // Bounce on release: level stays high, no pulse.
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Reset drops everything at once; an in-flight press produces no release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    // The hold counter saturates at LONG_CYCLES, so the pulse can only fire
    // on the single increment that reaches it: once per accepted press.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == PRESS_WAIT && state_d == HELD) begin
            hold_d = '0;
        end else if (state_d == IDLE) begin
            hold_d = '0;
        end else if ((state_q == HELD || state_q == RELEASE_WAIT) && hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_LAST - 1'b1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of the push-button conditioner with
// SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16. btn_raw changes 1 ns
// after a posedge, so a value set before step k is first sampled at edge k;
// outputs are sampled 1 ns after each posedge.
module tb_button_conditioner;
    import button_pkg::*;

`ifdef LONG_PRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    logic btn_raw;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int n_checks = 0;
    int n_pass   = 0;

    button_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: set btn_raw, advance one posedge, check all four outputs.
    task automatic step(input logic raw, input logic e_lvl, input logic e_prs,
                        input logic e_rel, input logic e_lng, input string tag);
        btn_raw = raw;
        @(posedge clk);
        #1;
        check_eq({tag, ".level"},   32'(btn_level),     32'(e_lvl));
        check_eq({tag, ".press"},   32'(press_pulse),   32'(e_prs));
        check_eq({tag, ".release"}, 32'(release_pulse), 32'(e_rel));
        check_eq({tag, ".long"},    32'(long_press),    32'(e_lng));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".level"},   32'(btn_level),     32'd0);
        check_eq({tag, ".press"},   32'(press_pulse),   32'd0);
        check_eq({tag, ".release"}, 32'(release_pulse), 32'd0);
        check_eq({tag, ".long"},    32'(long_press),    32'd0);
        check_eq({tag, ".state"},   32'(dut.state_q),   32'(IDLE));
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        // 1. Clean press: pulse and level at edge 7, pulse lasts one cycle.
        for (int k = 1; k <= 8; k++)
            step(1'b1, k >= 7, k == 7, 1'b0, 1'b0, $sformatf("t1_clean_press[%0d]", k));

        // 3. Release with bounce: 0,0,1 then 0 held; final fall before step 4.
        for (int k = 1; k <= 11; k++)
            step(k == 3, k < 10, 1'b0, k == 10, 1'b0, $sformatf("t3_release_bounce[%0d]", k));

        // 2. Press with bounce: 1,1,1,0 then 1 held; final rise before step 5.
        for (int k = 1; k <= 12; k++)
            step(k != 4, k >= 11, k == 11, 1'b0, 1'b0, $sformatf("t2_press_bounce[%0d]", k));

        // 4. Reset while HELD: outputs clear without waiting for a clock edge.
        @(posedge clk);
        #2;
        btn_raw = 1'b0;
        reset   = 1'b1;
        #1;
        check_idle_outputs("t4_reset_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 8; k++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("t4_after_reset[%0d]", k));
        check_idle_outputs("t4_idle");

        // 6. One-cycle glitch caught by a single edge: rejected in PRESS_WAIT.
        for (int k = 1; k <= 8; k++)
            step(k == 1, 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("t6_glitch[%0d]", k));
        check_idle_outputs("t6_idle");

        // 5. Long hold: press at step 7, long_press 16 edges later (step 23).
        begin
            int n_long = 0;
            for (int k = 1; k <= 48; k++) begin
                step(1'b1, k >= 7, k == 7, 1'b0, LP_ON && (k == 23),
                     $sformatf("t5_long[%0d]", k));
                if (long_press) n_long++;
            end
            check_eq("t5_long_count", 32'(n_long), LP_ON ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
